// File: rtl/pulse_feeder.sv
// pulse_feeder: holds matrices A (M x N) and B (N x L) and plays them out as
// skewed, zero-padded wavefronts for a systolic array.
// Row i of A is delayed by i cycles on lane i of 'left'. Column j of B is
// delayed by j cycles on lane j of 'up'.
module pulse_feeder #(
    parameter int WIDTH_left      = 4,
    parameter int WIDTH_up        = 4,
    parameter int Mritx_M         = 3,
    parameter int Mritx_N         = 4,
    parameter int Mritx_L         = 3,
    parameter int Mritx_LOG2_size = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_wr_en,
    input  logic [Mritx_LOG2_size-1:0]    a_wr_addr,
    input  logic [WIDTH_left-1:0]         a_wr_data,
    input  logic                          b_wr_en,
    input  logic [Mritx_LOG2_size-1:0]    b_wr_addr,
    input  logic [WIDTH_up-1:0]           b_wr_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [Mritx_M*WIDTH_left-1:0] left,
    output logic [Mritx_L*WIDTH_up-1:0]   up,
    output logic                          valid_left,
    output logic                          valid_up
);

    localparam int A_SIZE = Mritx_M * Mritx_N;
    localparam int B_SIZE = Mritx_N * Mritx_L;
    localparam int MAX_ML = (Mritx_M > Mritx_L) ? Mritx_M : Mritx_L;
    // Number of stream cycles: the last row/column needs N cycles after its skew.
    localparam int T_LEN  = Mritx_N + MAX_ML - 1;
    // Counter wide enough to hold T_LEN itself, so it can never wrap.
    localparam int TW     = (T_LEN >= 1) ? $clog2(T_LEN + 1) : 1;
    localparam int AIW    = (A_SIZE > 1) ? $clog2(A_SIZE) : 1;
    localparam int BIW    = (B_SIZE > 1) ? $clog2(B_SIZE) : 1;

    localparam logic [TW-1:0] T_LAST  = TW'(T_LEN - 1);
    localparam logic [TW-1:0] VL_LAST = TW'(Mritx_N + Mritx_M - 2);
    localparam logic [TW-1:0] VU_LAST = TW'(Mritx_N + Mritx_L - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                          state_r;
    logic [TW-1:0]                   t_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            valid_left_r;
    logic                            valid_up_r;
    logic [Mritx_M*WIDTH_left-1:0]   left_r;
    logic [Mritx_L*WIDTH_up-1:0]     up_r;
    logic [WIDTH_left-1:0]           a_mem_r [A_SIZE];
    logic [WIDTH_up-1:0]             b_mem_r [B_SIZE];

    // Next-cycle values
    state_t                          state_nxt_s;
    logic [TW-1:0]                   t_nxt_s;
    logic                            emit_s;
    logic                            busy_nxt_s;
    logic                            done_nxt_s;
    logic                            valid_left_nxt_s;
    logic                            valid_up_nxt_s;
    logic [Mritx_M*WIDTH_left-1:0]   left_nxt_s;
    logic [Mritx_L*WIDTH_up-1:0]     up_nxt_s;
    logic [WIDTH_left-1:0]           a_next_s [A_SIZE];
    logic [WIDTH_up-1:0]             b_next_s [B_SIZE];

    // Storage contents after this edge's write. Out-of-range addresses never
    // match any slot, and writes are locked out while streaming. The stream
    // values are built from this merged view so that a write landing on the
    // start edge is already visible at t=0.
    always_comb begin
        a_next_s = a_mem_r;
        b_next_s = b_mem_r;
        for (int k = 0; k < A_SIZE; k++) begin
            if (a_wr_en && !busy_r && (a_wr_addr == Mritx_LOG2_size'(k))) begin
                a_next_s[k] = a_wr_data;
            end else begin
                a_next_s[k] = a_mem_r[k];
            end
        end
        for (int k = 0; k < B_SIZE; k++) begin
            if (b_wr_en && !busy_r && (b_wr_addr == Mritx_LOG2_size'(k))) begin
                b_next_s[k] = b_wr_data;
            end else begin
                b_next_s[k] = b_mem_r[k];
            end
        end
    end

    // Sequencer: next state, next stream index and the control outputs.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        emit_s      = 1'b0;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = STREAM;
                    t_nxt_s     = '0;
                    emit_s      = 1'b1;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (t_r == T_LAST) begin
                    state_nxt_s = DONE;
                    t_nxt_s     = '0;
                    done_nxt_s  = 1'b1;
                end else begin
                    t_nxt_s     = t_r + TW'(1);
                    emit_s      = 1'b1;
                    busy_nxt_s  = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                t_nxt_s     = '0;
            end
        endcase
    end

    // Skewed lane data for the stream index about to be presented.
    always_comb begin
        left_nxt_s       = '0;
        up_nxt_s         = '0;
        valid_left_nxt_s = 1'b0;
        valid_up_nxt_s   = 1'b0;
        for (int i = 0; i < Mritx_M; i++) begin
            int d;
            d = int'(t_nxt_s) - i;
            if (emit_s && (d >= 0) && (d < Mritx_N)) begin
                left_nxt_s[i*WIDTH_left +: WIDTH_left] = a_next_s[AIW'(i * Mritx_N + d)];
            end else begin
                left_nxt_s[i*WIDTH_left +: WIDTH_left] = '0;
            end
        end
        for (int j = 0; j < Mritx_L; j++) begin
            int d;
            d = int'(t_nxt_s) - j;
            if (emit_s && (d >= 0) && (d < Mritx_N)) begin
                up_nxt_s[j*WIDTH_up +: WIDTH_up] = b_next_s[BIW'(d * Mritx_L + j)];
            end else begin
                up_nxt_s[j*WIDTH_up +: WIDTH_up] = '0;
            end
        end
        if (emit_s) begin
            valid_left_nxt_s = (t_nxt_s <= VL_LAST);
            valid_up_nxt_s   = (t_nxt_s <= VU_LAST);
        end else begin
            valid_left_nxt_s = 1'b0;
            valid_up_nxt_s   = 1'b0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            t_r          <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            valid_left_r <= 1'b0;
            valid_up_r   <= 1'b0;
            left_r       <= '0;
            up_r         <= '0;
        end else begin
            state_r      <= state_nxt_s;
            t_r          <= t_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            valid_left_r <= valid_left_nxt_s;
            valid_up_r   <= valid_up_nxt_s;
            left_r       <= left_nxt_s;
            up_r         <= up_nxt_s;
        end
    end

    // Matrix storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_mem_r <= '{default: '0};
            b_mem_r <= '{default: '0};
        end else begin
            a_mem_r <= a_next_s;
            b_mem_r <= b_next_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign left       = left_r;
    assign up         = up_r;
    assign valid_left = valid_left_r;
    assign valid_up   = valid_up_r;

endmodule
